// File: rtl/mod_exp_ctrl_if.sv
// Bundle between the exponentiation sequencer and its two helpers: the
// exponent shift register and the external modular multiplier.
//   sr_load/sr_shift/sr_din : shift-register control and parallel load data
//   sr_bit                  : shift-register serial output (current exponent LSB)
//   mm_start/mm_a/mm_b/mm_n : multiplier request, operands and modulus
//   mm_done/mm_p            : multiplier completion pulse and product
// master = sequencer, slave = shift register + multiplier side.
interface mod_exp_ctrl_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_WIDTH = 32
);
  logic                 sr_load;
  logic                 sr_shift;
  logic [EXP_WIDTH-1:0] sr_din;
  logic                 sr_bit;
  logic                 mm_start;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic [WIDTH-1:0]     mm_n;
  logic                 mm_done;
  logic [WIDTH-1:0]     mm_p;

  modport master (
    output sr_load, sr_shift, sr_din, mm_start, mm_a, mm_b, mm_n,
    input  sr_bit, mm_done, mm_p
  );

  modport slave (
    input  sr_load, sr_shift, sr_din, mm_start, mm_a, mm_b, mm_n,
    output sr_bit, mm_done, mm_p
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Sequencer for right-to-left binary modular exponentiation:
//   result = base^exponent mod modulus
// Square-always / multiply-on-1 schedule over exactly EXP_WIDTH iterations.
// The bit-dependent multiply is deliberately left unprotected.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   start             : begin run, accepted only while idle
//   exponent          : exponent, forwarded to the shift register load data
//   base, modulus     : operands, latched on an accepted start
//   busy              : run in progress
//   done              : one-cycle pulse, result valid
//   result            : final value, held until the next accepted start
//   bus (master)      : shift-register control and multiplier handshake
module mod_exp_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     base,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  mod_exp_ctrl_if.master       bus
);

  localparam int unsigned CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CHECK,
    MUL,
    MUL_WAIT,
    SQR,
    SQR_WAIT,
    NEXT,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] bit_cnt;

  // Single-process FSM; every output is a register set on the transition
  // into the state that owns it, so pulses line up with their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      acc          <= '0;
      b_reg        <= '0;
      bit_cnt      <= '0;
      bus.sr_load  <= 1'b0;
      bus.sr_shift <= 1'b0;
      bus.sr_din   <= '0;
      bus.mm_start <= 1'b0;
      bus.mm_a     <= '0;
      bus.mm_b     <= '0;
      bus.mm_n     <= '0;
    end else begin
      done         <= 1'b0;
      bus.sr_load  <= 1'b0;
      bus.sr_shift <= 1'b0;
      bus.mm_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            b_reg       <= base;
            bus.mm_n    <= modulus;
            bus.sr_din  <= exponent;
            acc         <= WIDTH'(1);
            bit_cnt     <= '0;
            busy        <= 1'b1;
            bus.sr_load <= 1'b1;
            state       <= LOAD;
          end
        end

        // Shift register captures sr_din at the end of this cycle.
        LOAD: state <= CHECK;

        CHECK: begin
          bus.mm_start <= 1'b1;
          bus.mm_b     <= b_reg;
          if (bus.sr_bit) begin
            bus.mm_a <= acc;
            state    <= MUL;
          end else begin
            bus.mm_a <= b_reg;
            state    <= SQR;
          end
        end

        MUL: state <= MUL_WAIT;

        MUL_WAIT: begin
          if (bus.mm_done) begin
            acc          <= bus.mm_p;
            bus.mm_start <= 1'b1;
            bus.mm_a     <= b_reg;
            bus.mm_b     <= b_reg;
            state        <= SQR;
          end
        end

        SQR: state <= SQR_WAIT;

        // The shift pulse is raised for the NEXT cycle so the register has
        // moved before the following CHECK samples sr_bit.
        SQR_WAIT: begin
          if (bus.mm_done) begin
            b_reg        <= bus.mm_p;
            bus.sr_shift <= (bit_cnt != LAST_BIT);
            state        <= NEXT;
          end
        end

        NEXT: begin
          if (bit_cnt == LAST_BIT) begin
            result <= acc;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            state   <= CHECK;
          end
        end

        // busy stays high here so a start coinciding with done is ignored.
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: mock multiplier, exponent shift register and a
// plain-arithmetic reference model for the result and the run length.
module tb_mod_exp_ctrl;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned EXP_WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] exponent;
  logic [31:0] base;
  logic [31:0] modulus;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mod_exp_ctrl_if #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) bus ();

  mod_exp_ctrl #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .exponent (exponent),
    .base     (base),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment configuration (written only by the stimulus block)
  bit lat_rand = 1'b0;
  bit spur_en  = 1'b0;

  // Environment state and monitors (written only by the negedge block)
  logic [31:0] sr_q = '0;
  int          pend = 0;
  logic [31:0] cap_a, cap_b, cap_n;
  int n_load = 0, n_shift = 0, n_start = 0, n_mul = 0, n_sq = 0, n_done = 0;
  int unstable = 0;
  int cyc = 0, cyc_last = 0;
  bit counting = 1'b0;

  assign bus.sr_bit = sr_q[0];

  function automatic logic [31:0] mulmod(logic [31:0] a, logic [31:0] b, logic [31:0] n);
    logic [63:0] prod;
    if (n == 32'd0) return 32'd0;
    prod = {32'd0, a} * {32'd0, b};
    return 32'(prod % {32'd0, n});
  endfunction

  // base^e mod n, scanning exponent bits and repeatedly squaring the base.
  function automatic logic [31:0] ref_modexp(logic [31:0] b, logic [31:0] e, logic [31:0] n);
    logic [31:0] r;
    logic [31:0] p;
    r = 32'd1;
    p = b;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = mulmod(r, p, n);
      p = mulmod(p, p, n);
    end
    return r;
  endfunction

  function automatic int popcnt(logic [31:0] e);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(e[i]);
    return c;
  endfunction

  function automatic int ref_cycles(logic [31:0] e, int l);
    return 2 + 32 * (3 + l) + popcnt(e) * (1 + l);
  endfunction

  // Shift register, mock multiplier (latency counted from mm_start) and pulse monitors.
  always @(negedge clk) begin
    bit          real_done;
    logic [63:0] prod;
    real_done   = 1'b0;
    bus.mm_done = 1'b0;

    if (bus.sr_load) begin
      n_load++;
      counting = 1'b1;
      cyc      = 0;
    end
    if (counting) cyc++;
    if (bus.sr_shift) n_shift++;
    if (bus.mm_start) begin
      n_start++;
      if (bus.mm_a != bus.mm_b) n_mul++;
      else n_sq++;
    end
    if (done) begin
      n_done++;
      if (counting) begin
        cyc_last = cyc;
        counting = 1'b0;
      end
    end

    if (bus.sr_load) sr_q = bus.sr_din;
    else if (bus.sr_shift) sr_q = sr_q >> 1;

    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        if (bus.mm_a !== cap_a || bus.mm_b !== cap_b || bus.mm_n !== cap_n) unstable++;
        pend--;
        if (pend == 0) begin
          real_done   = 1'b1;
          bus.mm_done = 1'b1;
          prod        = {32'd0, cap_a} * {32'd0, cap_b};
          bus.mm_p    = (cap_n == 32'd0) ? 32'd0 : 32'(prod % {32'd0, cap_n});
        end
      end
      if (bus.mm_start) begin
        cap_a = bus.mm_a;
        cap_b = bus.mm_b;
        cap_n = bus.mm_n;
        pend  = lat_rand ? int'($urandom_range(1, 8)) : 3;
      end else if (spur_en && !real_done && pend == 0 && $urandom_range(0, 2) == 0) begin
        bus.mm_done = 1'b1;
        bus.mm_p    = $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int s_load, s_shift, s_start, s_mul, s_sq, s_done, s_unst;

  task automatic snap();
    s_load  = n_load;
    s_shift = n_shift;
    s_start = n_start;
    s_mul   = n_mul;
    s_sq    = n_sq;
    s_done  = n_done;
    s_unst  = unstable;
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    @(negedge clk);
    base     = b;
    exponent = e;
    modulus  = n;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output logic [31:0] res);
    got = 1'b0;
    res = '0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        res = result;
      end
    end
  endtask

  initial begin
    bit          got;
    bit          found;
    logic [31:0] res;
    logic [31:0] rb, re, rn;

    reset    = 1'b1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(negedge clk);

    // Reset state, with start asserted while reset is held
    start = 1'b1;
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_done",     64'(done), 64'd0);
    chk("rst_result",   64'(result), 64'd0);
    chk("rst_mm_start", 64'(bus.mm_start), 64'd0);
    chk("rst_mm_a",     64'(bus.mm_a), 64'd0);
    chk("rst_mm_b",     64'(bus.mm_b), 64'd0);
    chk("rst_mm_n",     64'(bus.mm_n), 64'd0);
    chk("rst_sr_load",  64'(bus.sr_load), 64'd0);
    chk("rst_sr_shift", 64'(bus.sr_shift), 64'd0);
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Case 1: 4^13 mod 497
    snap();
    start_run(32'd4, 32'd13, 32'd497);
    wait_done(got, res);
    chk("c1_timeout", 64'(got), 64'd1);
    chk("c1_result", 64'(res), 64'd445);
    @(negedge clk);
    chk("c1_busy_after", 64'(busy), 64'd0);
    chk("c1_done_pulse", 64'(done), 64'd0);
    chk("c1_done_count", 64'(n_done - s_done), 64'd1);
    chk("c1_cycles", 64'(cyc_last), 64'(ref_cycles(32'd13, 3)));
    chk("c1_cycles_206", 64'(cyc_last), 64'd206);

    // Case 2: exponent 0 squares only
    snap();
    start_run(32'd7, 32'd0, 32'd11);
    wait_done(got, res);
    chk("c2_timeout", 64'(got), 64'd1);
    chk("c2_result", 64'(res), 64'd1);
    @(negedge clk);
    chk("c2_mm_starts", 64'(n_start - s_start), 64'd32);
    chk("c2_squares", 64'(n_sq - s_sq), 64'd32);
    chk("c2_mults", 64'(n_mul - s_mul), 64'd0);
    chk("c2_shifts", 64'(n_shift - s_shift), 64'd31);
    chk("c2_loads", 64'(n_load - s_load), 64'd1);

    // Case 3: dense exponent
    snap();
    start_run(32'd2, 32'h78ABCDEF, 32'd1000003);
    wait_done(got, res);
    chk("c3_timeout", 64'(got), 64'd1);
    chk("c3_result", 64'(res), 64'(ref_modexp(32'd2, 32'h78ABCDEF, 32'd1000003)));
    @(negedge clk);
    chk("c3_mults", 64'(n_mul - s_mul), 64'd21);
    chk("c3_squares", 64'(n_sq - s_sq), 64'd32);
    chk("c3_cycles", 64'(cyc_last), 64'(ref_cycles(32'h78ABCDEF, 3)));

    // Case 4: start held from mid-run through done must be ignored
    snap();
    start_run(32'd4, 32'd13, 32'd497);
    repeat (40) @(negedge clk);
    base  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    chk("c4_busy_mid", 64'(busy), 64'd1);
    wait_done(got, res);
    chk("c4_timeout", 64'(got), 64'd1);
    chk("c4_result", 64'(res), 64'd445);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("c4_busy_after", 64'(busy), 64'd0);
    chk("c4_no_restart", 64'(bus.sr_load), 64'd0);
    chk("c4_loads", 64'(n_load - s_load), 64'd1);
    chk("c4_done_count", 64'(n_done - s_done), 64'd1);

    // Case 5: reset during MUL_WAIT, then a fresh run
    snap();
    start_run(32'd4, 32'd13, 32'd497);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.mm_start && bus.mm_a != bus.mm_b) found = 1'b1;
    end
    chk("c5_mul_seen", 64'(found), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("c5_rst_busy", 64'(busy), 64'd0);
    chk("c5_rst_mm_start", 64'(bus.mm_start), 64'd0);
    chk("c5_rst_result", 64'(result), 64'd0);
    chk("c5_rst_mm_a", 64'(bus.mm_a), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_run(32'd4, 32'd13, 32'd497);
    wait_done(got, res);
    chk("c5_timeout", 64'(got), 64'd1);
    chk("c5_result", 64'(res), 64'd445);
    @(negedge clk);
    chk("c5_done_count", 64'(n_done - s_done), 64'd1);

    // Case 6: random latency and spurious mm_done outside the waits
    lat_rand = 1'b1;
    spur_en  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      snap();
      start_run(32'd4, 32'd13, 32'd497);
      wait_done(got, res);
      chk("c6_timeout", 64'(got), 64'd1);
      chk("c6_result", 64'(res), 64'd445);
      @(negedge clk);
      chk("c6_unstable", 64'(unstable - s_unst), 64'd0);
      chk("c6_done_count", 64'(n_done - s_done), 64'd1);
    end
    lat_rand = 1'b0;
    spur_en  = 1'b0;

    // Random operands at fixed latency
    for (int k = 0; k < 4; k++) begin
      rb = $urandom;
      re = $urandom;
      rn = $urandom | 32'd1;
      snap();
      start_run(rb, re, rn);
      wait_done(got, res);
      chk("rnd_timeout", 64'(got), 64'd1);
      chk("rnd_result", 64'(res), 64'(ref_modexp(rb, re, rn)));
      @(negedge clk);
      chk("rnd_cycles", 64'(cyc_last), 64'(ref_cycles(re, 3)));
      chk("rnd_mm_starts", 64'(n_start - s_start), 64'(32 + popcnt(re)));
    end

    // Modulus 0 is forwarded unchanged
    start_run(32'd3, 32'd5, 32'd0);
    wait_done(got, res);
    chk("m0_timeout", 64'(got), 64'd1);
    chk("m0_result", 64'(res), 64'(ref_modexp(32'd3, 32'd5, 32'd0)));
    chk("m0_mm_n", 64'(bus.mm_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
